// File: rtl/mcpu_control_fsm.sv
// mcpu_control_fsm: multi-cycle MCPU control sequencer driving datapath enables and mux selects,
// counting retired instructions and trapping on unsupported encodings.
module mcpu_control_fsm #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 PC_WE,
    output logic                 IR_WE,
    output logic                 A_WE,
    output logic                 B_WE,
    output logic                 BEN,
    output logic                 Reg_WE,
    output logic                 Mem_WE,
    output logic                 MemIn,
    output logic                 Dst,
    output logic                 Jal,
    output logic                 RegIn,
    output logic                 Immer,
    output logic                 BEQBNE,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic [2:0]           ALUOp,
    output logic [3:0]           state,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4,
        MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, I_EXEC = 4'd8, I_WB = 4'd9,
        BRANCH = 4'd10, JUMP = 4'd11, JR = 4'd12, TRAP = 4'd15
    } state_t;

    state_t state_q, state_d;
    logic [INSTRET_W-1:0] instret_q;
    logic pc_we, ir_we, a_we, b_we, ben_we, reg_we, mem_we;
    logic [2:0] r_op, i_op;
    logic i_xor;

    assign i_xor = opcode == 6'h0E;
    assign i_op  = i_xor ? 3'd2 : 3'd0;
    assign r_op  = funct == 6'h22 ? 3'd1 : funct == 6'h2A ? 3'd3 : 3'd0;

    always_comb begin
        state_d = state_q;
        {pc_we, ir_we, a_we, b_we, ben_we, reg_we, mem_we} = '0;
        {MemIn, Dst, Jal, RegIn, Immer, BEQBNE, halted} = '0;
        ALUSrcA = 2'd0;
        ALUSrcB = 2'd0;
        PCSrc = 2'd0;
        ALUOp = 3'd0;
        case (state_q)
            FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
                ALUSrcB = 2'd3;
                PCSrc = 2'd2;
                state_d = DECODE;
            end
            DECODE: begin
                {a_we, b_we, ben_we} = 3'b111;
                // JAL links here: the ALU reg still holds PC+4 from FETCH
                {reg_we, Jal, RegIn} = {3{opcode == 6'h03}};
                state_d = (opcode == 6'h23 || opcode == 6'h2B) ? MEM_ADDR :
                          (opcode == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h2A)) ? R_EXEC :
                          (opcode == 6'h00 && funct == 6'h08) ? JR :
                          (opcode == 6'h08 || opcode == 6'h0E) ? I_EXEC :
                          (opcode == 6'h04 || opcode == 6'h05) ? BRANCH :
                          (opcode == 6'h02 || opcode == 6'h03) ? JUMP : TRAP;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd1;
                state_d = opcode == 6'h23 ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                MemIn = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                Dst = 1'b1;
                reg_we = 1'b1;
                state_d = FETCH;
            end
            MEM_WRITE: begin
                MemIn = 1'b1;
                mem_we = 1'b1;
                state_d = FETCH;
            end
            R_EXEC: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ALUOp = r_op;
                state_d = R_WB;
            end
            R_WB: begin
                RegIn = 1'b1;
                reg_we = 1'b1;
                ALUOp = r_op;
                state_d = FETCH;
            end
            I_EXEC: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd1;
                Immer = i_xor;
                ALUOp = i_op;
                state_d = I_WB;
            end
            I_WB: begin
                Dst = 1'b1;
                RegIn = 1'b1;
                reg_we = 1'b1;
                Immer = i_xor;
                ALUOp = i_op;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ALUOp = 3'd1;
                BEQBNE = opcode == 6'h05;
                pc_we = zero ^ BEQBNE;
                state_d = FETCH;
            end
            JUMP: begin
                PCSrc = 2'd1;
                pc_we = 1'b1;
                state_d = FETCH;
            end
            JR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                PCSrc = 2'd2;
                pc_we = 1'b1;
                state_d = FETCH;
            end
            TRAP: halted = 1'b1;
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != FETCH && state_d == FETCH)
                instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Reset masks every write so an abandoned instruction leaves no partial update
    assign {PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE} =
        {pc_we, ir_we, a_we, b_we, ben_we, reg_we, mem_we} & {7{~reset}};
    assign state = state_q;
    assign instret = instret_q;
endmodule

// File: tb/tb_mcpu_control_fsm.sv
// tb_mcpu_control_fsm: directed instruction sequences checked each cycle against a per-instruction plan.
module tb_mcpu_control_fsm;
    typedef struct packed {
        logic pc_we, ir_we, a_we, b_we, ben, reg_we, mem_we;
        logic mem_in, dst, jal, reg_in, immer, beqbne;
        logic [1:0] src_a, src_b, pc_src;
        logic [2:0] alu_op;
        logic [3:0] st;
        logic halted;
    } ctl_t;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE, MemIn, Dst, Jal, RegIn, Immer, BEQBNE, halted;
    logic [1:0] ALUSrcA, ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic [31:0] instret;

    mcpu_control_fsm #(.INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PC_WE(PC_WE), .IR_WE(IR_WE), .A_WE(A_WE), .B_WE(B_WE), .BEN(BEN), .Reg_WE(Reg_WE),
        .Mem_WE(Mem_WE), .MemIn(MemIn), .Dst(Dst), .Jal(Jal), .RegIn(RegIn), .Immer(Immer),
        .BEQBNE(BEQBNE), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .state(state), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    ctl_t dut_c, exp_c;
    ctl_t exp_q[$];
    assign dut_c = {PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE, MemIn, Dst, Jal, RegIn, Immer,
                    BEQBNE, ALUSrcA, ALUSrcB, PCSrc, ALUOp, state, halted};

    int errs = 0, total = 0;
    int unsigned cnt = 0;
    bit chk_en = 1'b0;
    logic [63:0] obs, o;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s act=%h exp=%h", n, a, e);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("ctl", 64'(dut_c), 64'(exp_c));
        chk("instret", 64'(instret), 64'(cnt));
        obs = {obs[59:0], state};
    end

    // Expected per-cycle control for one instruction, read off the instruction's semantics
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z);
        ctl_t c;
        logic [2:0] aop;
        exp_q.delete();
        c = '0; c.ir_we = 1; c.pc_we = 1; c.src_b = 3; c.pc_src = 2; exp_q.push_back(c);
        c = '0; c.st = 1; c.a_we = 1; c.b_we = 1; c.ben = 1;
        if (op == 6'h03) begin c.reg_we = 1; c.jal = 1; c.reg_in = 1; end
        exp_q.push_back(c);
        if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.st = 2; c.src_a = 1; c.src_b = 1; exp_q.push_back(c);
            if (op == 6'h23) begin
                c = '0; c.st = 3; c.mem_in = 1; exp_q.push_back(c);
                c = '0; c.st = 4; c.dst = 1; c.reg_we = 1; exp_q.push_back(c);
            end else begin
                c = '0; c.st = 5; c.mem_in = 1; c.mem_we = 1; exp_q.push_back(c);
            end
        end else if (op == 0 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
            aop = fn == 6'h20 ? 3'd0 : fn == 6'h22 ? 3'd1 : 3'd3;
            c = '0; c.st = 6; c.src_a = 1; c.src_b = 2; c.alu_op = aop; exp_q.push_back(c);
            c = '0; c.st = 7; c.reg_in = 1; c.reg_we = 1; c.alu_op = aop; exp_q.push_back(c);
        end else if (op == 0 && fn == 6'h08) begin
            c = '0; c.st = 12; c.src_a = 1; c.src_b = 2; c.pc_src = 2; c.pc_we = 1; exp_q.push_back(c);
        end else if (op == 6'h08 || op == 6'h0E) begin
            aop = op == 6'h0E ? 3'd2 : 3'd0;
            c = '0; c.st = 8; c.src_a = 1; c.src_b = 1; c.immer = op == 6'h0E; c.alu_op = aop; exp_q.push_back(c);
            c = '0; c.st = 9; c.dst = 1; c.reg_in = 1; c.reg_we = 1; c.immer = op == 6'h0E; c.alu_op = aop;
            exp_q.push_back(c);
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.st = 10; c.src_a = 1; c.src_b = 2; c.alu_op = 1; c.beqbne = op == 6'h05;
            c.pc_we = (z == 1'b1) == (op == 6'h04); exp_q.push_back(c);
        end else if (op == 6'h02 || op == 6'h03) begin
            c = '0; c.st = 11; c.pc_src = 1; c.pc_we = 1; exp_q.push_back(c);
        end else begin
            c = '0; c.st = 15; c.halted = 1;
            repeat (10) exp_q.push_back(c);
        end
    endtask

    // Starts at posedge+2 and ends at posedge+2; maxs>0 stops early without retiring
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int maxs,
                       output logic [63:0] r);
        int n;
        plan(op, fn, z);
        n = (maxs > 0) ? maxs : exp_q.size();
        opcode = op; funct = fn; zero = z; obs = '0;
        for (int i = 0; i < n; i++) begin
            exp_c = exp_q[i];
            chk_en = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #2;
        end
        chk_en = 1'b0;
        if (maxs == 0 && exp_q[exp_q.size()-1].st != 4'd15) cnt++;
        r = obs;
    endtask

    task automatic reset_checks(input string n);
        chk({n, "_we"}, 64'({PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE}), 64'd0);
        chk({n, "_state"}, 64'(state), 64'd0);
        chk({n, "_instret"}, 64'(instret), 64'd0);
        chk({n, "_halted"}, 64'(halted), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset_checks("por");
        reset = 1'b0; cnt = 0;
        run(6'h23, 6'h00, 1'b0, 0, o); chk("lw_seq", o, 64'h01234);
        run(6'h2B, 6'h00, 1'b0, 0, o); chk("sw_seq", o, 64'h0125);
        run(6'h00, 6'h22, 1'b0, 0, o); chk("sub_seq", o, 64'h0167);
        run(6'h00, 6'h20, 1'b1, 0, o);
        run(6'h00, 6'h2A, 1'b0, 0, o);
        run(6'h08, 6'h3F, 1'b0, 0, o); chk("addi_seq", o, 64'h0189);
        run(6'h0E, 6'h00, 1'b1, 0, o);
        run(6'h04, 6'h00, 1'b1, 0, o); chk("beq_seq", o, 64'h01A);
        run(6'h04, 6'h00, 1'b0, 0, o);
        run(6'h05, 6'h00, 1'b1, 0, o);
        run(6'h05, 6'h00, 1'b0, 0, o);
        run(6'h02, 6'h00, 1'b0, 0, o); chk("j_seq", o, 64'h01B);
        run(6'h03, 6'h00, 1'b0, 0, o); chk("jal_seq", o, 64'h01B);
        run(6'h00, 6'h08, 1'b0, 0, o); chk("jr_seq", o, 64'h01C);
        chk("instret_14", 64'(instret), 64'd14);
        run(6'h23, 6'h00, 1'b0, 2, o);
        chk("pre_rst_state", 64'(state), 64'd2);
        #5 reset = 1'b1;
        #1 reset_checks("mid");
        @(posedge clk);
        #2 reset_checks("hold");
        reset = 1'b0; cnt = 0;
        run(6'h00, 6'h20, 1'b0, 0, o); chk("after_rst_seq", o, 64'h0167);
        run(6'h3F, 6'h00, 1'b0, 0, o); chk("trap_seq", o, 64'h01FF_FFFF_FFFF);
        chk("trap_halted", 64'(halted), 64'd1);
        chk("trap_instret", 64'(instret), 64'd1);
        #5 reset = 1'b1;
        #1 reset_checks("trap_rst");
        @(posedge clk);
        #2 reset = 1'b0; cnt = 0;
        run(6'h05, 6'h00, 1'b1, 0, o); chk("bne_seq", o, 64'h01A);
        chk("instret_1", 64'(instret), 64'd1);
        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end
endmodule

// File: doc/mcpu_control_fsm.md
# mcpu_control_fsm

Multi-cycle control state machine that sequences the MCPU datapath: PC, IR, A/B, ALU, BEN and MDR registers, regfile, memory and the ALU/PC/regfile/memory muxes. Each cycle it decodes the latched opcode/funct and the ALU zero flag, then drives every write enable and mux select. It also counts retired instructions and traps on unsupported encodings. It replaces the per-state control outputs of the instruction-parse LUT.

## Interface
Parameters:
- INSTRET_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE  out  1 each  register, regfile and memory write enables
- MemIn  out  1  memory address: 0 = PC, 1 = ALU reg
- Dst  out  1  write register: 0 = rd, 1 = rt
- Jal  out  1  1 forces write register to 31
- RegIn  out  1  write data: 0 = MDR, 1 = ALU reg
- Immer  out  1  0 = sign-extended imm16, 1 = zero-extended imm16
- BEQBNE  out  1  0 = beq, 1 = bne
- ALUSrcA  out  2  0 = PC, 1 = A, 2 = BEN reg, 3 = 0
- ALUSrcB  out  2  0 = imm<<2, 1 = imm, 2 = B, 3 = 4
- PCSrc  out  2  0 = branch target, 1 = jump concat, 2 = ALU out, 3 = ALU reg
- ALUOp  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT
- state  out  4  current state, for debug
- halted  out  1  sticky trap flag
- instret  out  INSTRET_W  retired-instruction count

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JR 12, TRAP 15. Codes 13 and 14 go to TRAP.
- Any output not listed for a state is 0.
- FETCH: MemIn=0, IR_WE=1, ALUSrcA=0, ALUSrcB=3, ADD, PCSrc=2, PC_WE=1. Next state DECODE.
- DECODE: A_WE=B_WE=1, BEN=1, ALUSrcA=0, ALUSrcB=0, ADD, which latches the branch target.
  - If opcode=0x03 (JAL), also Reg_WE=1, Jal=1, RegIn=1. The ALU reg still holds PC+4 from FETCH.
- DECODE next state:
  - 0x23/0x2B → MEM_ADDR
  - 0x00 with funct 0x20/0x22/0x2A → R_EXEC
  - 0x00 with funct 0x08 → JR
  - 0x08/0x0E → I_EXEC
  - 0x04/0x05 → BRANCH
  - 0x02/0x03 → JUMP
  - anything else → TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=1, ADD. Next: MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: MemIn=1. Next MEM_WB.
- MEM_WB: Dst=1, RegIn=0, Reg_WE=1. Next FETCH.
- MEM_WRITE: MemIn=1, Mem_WE=1. Next FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=2, ALUOp from funct (0x20 ADD, 0x22 SUB, 0x2A SLT). Next R_WB.
- R_WB: Dst=0, RegIn=1, Reg_WE=1. ALUOp is held at the R_EXEC value. Next FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=1. ADDI uses ADD with Immer=0; XORI uses XOR with Immer=1. Next I_WB.
- I_WB: Dst=1, RegIn=1, Reg_WE=1. Immer and ALUOp are held. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=2, SUB, BEQBNE=(opcode==0x05), PCSrc=0. PC_WE = zero XOR BEQBNE, combinational on zero. Next FETCH.
- JUMP: PCSrc=1, PC_WE=1. Next FETCH.
- JR: ALUSrcA=1, ALUSrcB=2, ADD (rt=0 gives B=0), PCSrc=2, PC_WE=1. Next FETCH.
- TRAP: all enables 0, halted=1. Exit only by reset.
- instret: increments by 1 on every transition into FETCH from a non-FETCH state. Wraps modulo 2^INSTRET_W.

## Timing
- Reset asserted: state=FETCH, halted=0, instret=0 immediately (asynchronous).
- While reset is high, every write enable (PC_WE, IR_WE, A_WE, B_WE, BEN, Reg_WE, Mem_WE) is forced to 0.
- First FETCH is on the first rising edge after reset deasserts.
- Reset mid-instruction abandons it. No partial writes occur after reset asserts.
- Outputs are combinational from state. Exceptions: PC_WE in BRANCH (depends on zero), Reg_WE/Jal/RegIn in DECODE (depend on opcode), and ALUOp/Immer (depend on opcode/funct).
- opcode and funct must stay stable from DECODE until FETCH, which holds because IR_WE asserts only in FETCH.
- Cycles per instruction: LW 5, SW 4, R-type 4, ADDI/XORI 4, BEQ/BNE 3, J/JAL 3, JR 3.
- Illegal encoding: TRAP on the edge ending DECODE. instret does not count it.

## Test plan
- Reset pulse mid-MEM_ADDR → state=0, instret=0 and all enables 0 during reset; FETCH cycle outputs on the first edge after release.
- LW (0x23) → state sequence 0,1,2,3,4,0; MEM_WB has Dst=1, RegIn=0, Reg_WE=1; instret +1.
- R-type SUB (funct 0x22) → R_EXEC has ALUOp=1, ALUSrcB=2; R_WB has Reg_WE=1, Dst=0; 4 cycles.
- BEQ with zero=1 → PC_WE=1, PCSrc=0. BNE with zero=1 → PC_WE=0, BEQBNE=1. Each takes 3 cycles.
- JAL (0x03) → DECODE has Reg_WE=1, Jal=1, RegIn=1; JUMP has PC_WE=1, PCSrc=1.
- Opcode 0x3F → TRAP, halted=1, no enables asserted for 10 cycles; reset clears halted.
